// File: rtl/shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_ctrl
// Description : Multi-cycle sequencer that steps a single-bit shift unit
//               N times, feeding its result back each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_ctrl #(
    parameter int W     = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic [W-1:0]     operand,
    output logic [W-1:0]     sh_in,
    output logic [1:0]       sh_op,
    input  logic [W-1:0]     sh_out,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_value;
    logic [AMT_W-1:0] r_count;
    logic [1:0]       r_sh_op;
    logic             r_busy;
    logic             r_done;

    // The stored op doubles as the shift-unit code: it is only non-zero in RUN.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_value <= '0;
            r_count <= '0;
            r_sh_op <= 2'b00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_value <= operand;
                        r_count <= amount;
                        r_busy  <= 1'b1;
                        if (amount == '0 || op == 2'b00) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_sh_op <= 2'b00;
                        end else begin
                            r_state <= S_RUN;
                            r_sh_op <= op;
                        end
                    end
                end
                S_RUN: begin
                    r_value <= sh_out;
                    r_count <= r_count - AMT_W'(1);
                    if (r_count == AMT_W'(1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_sh_op <= 2'b00;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_sh_op <= 2'b00;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_sh_op <= 2'b00;
                end
            endcase
        end
    end

    assign sh_in  = r_value;
    assign result = r_value;
    assign sh_op  = r_sh_op;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
`default_nettype wire
